// File: rtl/emperor_axi_lite_regfile.sv
// AXI4-Lite slave register bank: NUM_REGS registers, each RW or RO (per RO_MASK),
// byte-strobed writes, single outstanding write and read, SLVERR on illegal access.

module emperor_axi_lite_regfile_slot #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                    aclk,
  input  logic                    arst,
  input  logic                    we_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic [DATA_WIDTH-1:0]   q_o
);
  logic [DATA_WIDTH-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    for (int b = 0; b < DATA_WIDTH/8; b++)
      if (wstrb_i[b]) slot_d[b*8 +: 8] = wdata_i[b*8 +: 8];
  end

  always_ff @(posedge aclk) begin
    if (arst)      slot_q <= RESET_VAL;
    else if (we_i) slot_q <= slot_d;
  end

  assign q_o = slot_q;
endmodule

module emperor_axi_lite_regfile #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           aclk,
  input  logic                           arst,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_awaddr,
  input  logic [2:0]                     S_AXI_awprot,
  input  logic                           S_AXI_awvalid,
  output logic                           S_AXI_awready,
  input  logic [DATA_WIDTH-1:0]          S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_wstrb,
  input  logic                           S_AXI_wvalid,
  output logic                           S_AXI_wready,
  output logic [1:0]                     S_AXI_bresp,
  output logic                           S_AXI_bvalid,
  input  logic                           S_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_araddr,
  input  logic [2:0]                     S_AXI_arprot,
  input  logic                           S_AXI_arvalid,
  output logic                           S_AXI_arready,
  output logic [DATA_WIDTH-1:0]          S_AXI_rdata,
  output logic [1:0]                     S_AXI_rresp,
  output logic                           S_AXI_rvalid,
  input  logic                           S_AXI_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rdata,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int         BW          = DATA_WIDTH / 8;
  localparam int         ADDR_LSB    = $clog2(BW);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BW-1:0]         wstrb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_hs, w_hs, ar_hs, commit, w_ok, r_ok;
  logic [ADDR_WIDTH-1:0] waddr_eff, widx, ridx;
  logic [DATA_WIDTH-1:0] wdata_eff, rd_val;
  logic [BW-1:0]         wstrb_eff;
  logic [NUM_REGS-1:0]   wsel, rsel, wr_en;
  logic                  unused_ok;

  // Readies depend only on state and reset, never on an incoming valid.
  assign S_AXI_awready = !arst && !aw_held_q && !bvalid_q;
  assign S_AXI_wready  = !arst && !w_held_q  && !bvalid_q;
  assign S_AXI_arready = !arst && !rvalid_q;

  assign aw_hs = S_AXI_awvalid && S_AXI_awready;
  assign w_hs  = S_AXI_wvalid  && S_AXI_wready;
  assign ar_hs = S_AXI_arvalid && S_AXI_arready;

  // Commit on the edge where the second of AW/W lands (or both together).
  assign commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign waddr_eff = aw_held_q ? awaddr_q : S_AXI_awaddr;
  assign wdata_eff = w_held_q  ? wdata_q  : S_AXI_wdata;
  assign wstrb_eff = w_held_q  ? wstrb_q  : S_AXI_wstrb;

  assign widx = waddr_eff    >> ADDR_LSB;
  assign ridx = S_AXI_araddr >> ADDR_LSB;

  // Out-of-range indices match no slot, so an empty select means SLVERR.
  always_comb begin
    wsel   = '0;
    rsel   = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wsel[i] = (widx == ADDR_WIDTH'(i));
      rsel[i] = (ridx == ADDR_WIDTH'(i));
      if (rsel[i])
        rd_val = RO_MASK[i] ? hw_rdata[i*DATA_WIDTH +: DATA_WIDTH]
                            : reg_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_ok  = |(wsel & ~RO_MASK);
  assign r_ok  = |rsel;
  assign wr_en = commit ? (wsel & ~RO_MASK) : '0;

  always_ff @(posedge aclk) begin
    if (arst) begin
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      wr_pulse_q <= wr_en;
      if (bvalid_q && S_AXI_bready) bvalid_q <= 1'b0;
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= w_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          awaddr_q  <= S_AXI_awaddr;
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          wdata_q  <= S_AXI_wdata;
          wstrb_q  <= S_AXI_wstrb;
        end
      end
      // Read sees register state before any same-edge write commit.
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= r_ok ? rd_val : '0;
        rresp_q  <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && S_AXI_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (RO_MASK[g]) begin : g_ro
      assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_rw
      emperor_axi_lite_regfile_slot #(
        .DATA_WIDTH(DATA_WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_slot (
        .aclk   (aclk),
        .arst   (arst),
        .we_i   (wr_en[g]),
        .wdata_i(wdata_eff),
        .wstrb_i(wstrb_eff),
        .q_o    (reg_q[g*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  end

  assign S_AXI_bvalid = bvalid_q;
  assign S_AXI_bresp  = bresp_q;
  assign S_AXI_rvalid = rvalid_q;
  assign S_AXI_rresp  = rresp_q;
  assign S_AXI_rdata  = rdata_q;
  assign wr_pulse     = wr_pulse_q;

  assign unused_ok = ^{S_AXI_awprot, S_AXI_arprot};
endmodule

// File: tb/tb_emperor_axi_lite_regfile.sv
// Directed bench for emperor_axi_lite_regfile: 16x32b bank, register 3 read-only.
module tb_emperor_axi_lite_regfile;
  localparam int AW = 32, DW = 32, NR = 16;

  logic               aclk = 1'b0, arst = 1'b1;
  logic [AW-1:0]      awaddr = '0, araddr = '0;
  logic [2:0]         awprot = '0, arprot = '0;
  logic               awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic               arvalid = 1'b0, rready = 1'b0;
  logic [DW-1:0]      wdata = '0;
  logic [DW/8-1:0]    wstrb = '0;
  logic               awready, wready, bvalid, arready, rvalid;
  logic [1:0]         bresp, rresp;
  logic [DW-1:0]      rdata;
  logic [NR*DW-1:0]   reg_q, hw_rdata, exp_regs;
  logic [NR-1:0]      wr_pulse;

  int total = 0, bad = 0;

  always #5 aclk = ~aclk;

  emperor_axi_lite_regfile #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
    .RO_MASK(16'h0008), .RESET_VAL(32'h0)
  ) dut (
    .aclk(aclk), .arst(arst),
    .S_AXI_awaddr(awaddr), .S_AXI_awprot(awprot), .S_AXI_awvalid(awvalid),
    .S_AXI_awready(awready),
    .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wvalid(wvalid),
    .S_AXI_wready(wready),
    .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid), .S_AXI_bready(bready),
    .S_AXI_araddr(araddr), .S_AXI_arprot(arprot), .S_AXI_arvalid(arvalid),
    .S_AXI_arready(arready),
    .S_AXI_rdata(rdata), .S_AXI_rresp(rresp), .S_AXI_rvalid(rvalid),
    .S_AXI_rready(rready),
    .reg_q(reg_q), .hw_rdata(hw_rdata), .wr_pulse(wr_pulse)
  );

  task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sit 1ns past it for both checking and driving.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    hw_rdata = '0;
    hw_rdata[3*DW +: DW] = 32'hCAFE0001;
    hw_rdata[0 +: DW]    = 32'h12345678;
    exp_regs = '0;

    // Reset
    tick(); tick();
    chk("rst_awready", awready, 0);
    chk("rst_wready",  wready,  0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid",  bvalid,  0);
    chk("rst_rvalid",  rvalid,  0);
    chk("rst_regs",    reg_q,   exp_regs);
    chk("rst_pulse",   wr_pulse, 0);
    arst = 1'b0;
    tick();
    chk("idle_awready", awready, 1);
    chk("idle_arready", arready, 1);

    // AW+W same cycle to reg2
    awaddr = 32'h8; awvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    exp_regs[2*DW +: DW] = 32'hDEADBEEF;
    chk("t1_bvalid", bvalid, 1);
    chk("t1_bresp",  bresp,  2'b00);
    chk("t1_pulse",  wr_pulse, 16'h0004);
    chk("t1_regs",   reg_q, exp_regs);
    chk("t1_awready_busy", awready, 0);
    tick();
    chk("t1_pulse_once", wr_pulse, 0);
    chk("t1_bvalid_hold", bvalid, 1);
    bready = 1;
    tick();
    bready = 0;
    chk("t1_bvalid_clr", bvalid, 0);
    chk("t1_awready_back", awready, 1);

    // W three cycles ahead of AW, partial strobes into reg1
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
    tick();
    wvalid = 0;
    chk("t2_wready_held", wready, 0);
    chk("t2_awready_open", awready, 1);
    tick(); tick();
    chk("t2_no_early_b", bvalid, 0);
    awaddr = 32'h4; awvalid = 1;
    tick();
    awvalid = 0;
    exp_regs[1*DW +: DW] = 32'h00220044;
    chk("t2_regs",   reg_q, exp_regs);
    chk("t2_bvalid", bvalid, 1);
    chk("t2_pulse",  wr_pulse, 16'h0002);
    tick();
    chk("t2_awready_wait", awready, 0);
    chk("t2_wready_wait",  wready,  0);
    bready = 1;
    tick();
    bready = 0;
    chk("t2_awready_free", awready, 1);
    chk("t2_wready_free",  wready,  1);

    // Out-of-range write and read at 0x40
    awaddr = 32'h40; awvalid = 1; wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1;
    araddr = 32'h40; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("t3_bresp",  bresp, 2'b10);
    chk("t3_pulse",  wr_pulse, 0);
    chk("t3_rvalid", rvalid, 1);
    chk("t3_rresp",  rresp, 2'b10);
    chk("t3_rdata",  rdata, 0);
    chk("t3_regs",   reg_q, exp_regs);
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    chk("t3_rvalid_clr", rvalid, 0);

    // Read-only register 3
    araddr = 32'hC; arvalid = 1;
    tick();
    arvalid = 0;
    chk("t4_rdata", rdata, 32'hCAFE0001);
    chk("t4_rresp", rresp, 2'b00);
    rready = 1;
    tick();
    rready = 0;
    awaddr = 32'hC; awvalid = 1; wdata = 32'h55555555; wstrb = 4'hF; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("t4_bresp", bresp, 2'b10);
    chk("t4_pulse", wr_pulse, 0);
    chk("t4_regs",  reg_q, exp_regs);
    bready = 1;
    tick();
    bready = 0;

    // Read and write commit to reg2 on the same edge; then stall rready
    awaddr = 32'h8; awvalid = 1; wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1;
    araddr = 32'h8; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    araddr = 32'hC; arvalid = 1;
    exp_regs[2*DW +: DW] = 32'h0BADF00D;
    chk("t5_old_value", rdata, 32'hDEADBEEF);
    chk("t5_regs", reg_q, exp_regs);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_rvalid_hold", rvalid, 1);
      chk("t5_rdata_hold", rdata, 32'hDEADBEEF);
      chk("t5_arready_low", arready, 0);
    end
    arvalid = 0; rready = 1; bready = 1;
    tick();
    rready = 0; bready = 0;
    chk("t5_rvalid_clr", rvalid, 0);

    // Reset with a write response pending
    awaddr = 32'h14; awvalid = 1; wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    chk("t6_bvalid_pre", bvalid, 1);
    arst = 1;
    tick();
    exp_regs = '0;
    chk("t6_bvalid_rst", bvalid, 0);
    chk("t6_regs_rst", reg_q, exp_regs);
    chk("t6_awready_rst", awready, 0);
    arst = 0;
    // AW held, then reset drops it
    awaddr = 32'h18; awvalid = 1;
    tick();
    awvalid = 0;
    chk("t6_aw_held", awready, 0);
    arst = 1;
    tick();
    arst = 0;
    tick();
    wdata = 32'h00000077; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    chk("t6_aw_dropped", bvalid, 0);
    awaddr = 32'h18; awvalid = 1;
    tick();
    awvalid = 0;
    exp_regs[6*DW +: DW] = 32'h00000077;
    chk("t6_fresh_bvalid", bvalid, 1);
    chk("t6_fresh_bresp", bresp, 2'b00);
    chk("t6_fresh_pulse", wr_pulse, 16'h0040);
    chk("t6_fresh_regs", reg_q, exp_regs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
